// File: rtl/pll_rst_seq.sv
// PLL reset sequencer: pulses PLL RESETB, qualifies lock, releases a synchronous
// system reset, retries a PLL that never locks and latches a sticky fault.
module pll_rst_seq #(
  parameter int SYNC_STAGES  = 2,
  parameter int LOCK_HOLD    = 1024,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int PLL_RST_LEN  = 16,
  parameter int MAX_RETRY    = 3,
  parameter int CNT_W        = 17
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       lock_i,
  output logic       pll_resetb_o,
  output logic       sys_rst_n_o,
  output logic       ready_o,
  output logic       lock_lost_o,
  output logic       fault_o,
  output logic [3:0] retry_cnt_o
);

  localparam int RETRY_W = ($clog2(MAX_RETRY + 1) > 4) ? $clog2(MAX_RETRY + 1) : 4;

  typedef enum logic [2:0] {
    S_PLL_RST,
    S_WAIT_LOCK,
    S_HOLD,
    S_RUN,
    S_FAULT
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_next;
  logic [RETRY_W-1:0]   r_retry;
  logic [RETRY_W-1:0]   w_retry_next;
  logic                 w_lost_next;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                 w_lock_s;
  logic                 r_pll_resetb;
  logic                 r_sys_rst_n;
  logic                 r_ready;
  logic                 r_lock_lost;
  logic                 r_fault;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], lock_i};
    end
  end

  assign w_lock_s = r_sync[SYNC_STAGES-1];

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_retry_next = r_retry;
    w_lost_next  = 1'b0;
    case (r_state)
      S_PLL_RST: begin
        if (r_cnt == CNT_W'(PLL_RST_LEN - 1)) begin
          w_state_next = S_WAIT_LOCK;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      S_WAIT_LOCK: begin
        // Lock is tested first so a lock arriving on the timeout cycle wins.
        if (w_lock_s) begin
          w_state_next = S_HOLD;
          w_cnt_next   = '0;
        end else if (r_cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
          w_cnt_next = '0;
          if (r_retry == RETRY_W'(MAX_RETRY)) begin
            w_state_next = S_FAULT;
          end else begin
            w_retry_next = r_retry + RETRY_W'(1);
            w_state_next = S_PLL_RST;
          end
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (!w_lock_s) begin
          w_state_next = S_WAIT_LOCK;
          w_cnt_next   = '0;
        end else if (r_cnt == CNT_W'(LOCK_HOLD - 1)) begin
          w_state_next = S_RUN;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      S_RUN: begin
        if (!w_lock_s) begin
          w_state_next = S_PLL_RST;
          w_cnt_next   = '0;
          w_retry_next = '0;
          w_lost_next  = 1'b1;
        end
      end
      S_FAULT: begin
        w_state_next = S_FAULT;
      end
      default: begin
        w_state_next = S_PLL_RST;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state      <= S_PLL_RST;
      r_cnt        <= '0;
      r_retry      <= '0;
      r_pll_resetb <= 1'b0;
      r_sys_rst_n  <= 1'b0;
      r_ready      <= 1'b0;
      r_lock_lost  <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_retry      <= w_retry_next;
      r_pll_resetb <= (w_state_next == S_WAIT_LOCK) || (w_state_next == S_HOLD) ||
                      (w_state_next == S_RUN);
      r_sys_rst_n  <= (w_state_next == S_RUN);
      r_ready      <= (w_state_next == S_RUN);
      r_lock_lost  <= w_lost_next;
      r_fault      <= (w_state_next == S_FAULT);
    end
  end

  assign pll_resetb_o = r_pll_resetb;
  assign sys_rst_n_o  = r_sys_rst_n;
  assign ready_o      = r_ready;
  assign lock_lost_o  = r_lock_lost;
  assign fault_o      = r_fault;
  assign retry_cnt_o  = (r_retry > RETRY_W'(15)) ? 4'hF : r_retry[3:0];

endmodule

// File: tb/tb_pll_rst_seq.sv
// Bench for pll_rst_seq: countdown-based phase model checked every cycle, plus
// directed scenarios with hand-computed edge counts.
module tb_pll_rst_seq;

  localparam int SYNC     = 2;
  localparam int HOLD     = 8;
  localparam int TOUT     = 32;
  localparam int PRST_LEN = 4;
  localparam int MAXR     = 2;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       lock  = 1'b0;
  logic       pll_resetb_o;
  logic       sys_rst_n_o;
  logic       ready_o;
  logic       lock_lost_o;
  logic       fault_o;
  logic [3:0] retry_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pll_rst_seq #(
    .SYNC_STAGES (SYNC),
    .LOCK_HOLD   (HOLD),
    .LOCK_TIMEOUT(TOUT),
    .PLL_RST_LEN (PRST_LEN),
    .MAX_RETRY   (MAXR),
    .CNT_W       (17)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .lock_i      (lock),
    .pll_resetb_o(pll_resetb_o),
    .sys_rst_n_o (sys_rst_n_o),
    .ready_o     (ready_o),
    .lock_lost_o (lock_lost_o),
    .fault_o     (fault_o),
    .retry_cnt_o (retry_cnt_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: which phase the sequencer is in and how many cycles remain in it.
  typedef enum {PH_PRST, PH_WAIT, PH_QUAL, PH_RUN, PH_FAULT} phase_t;
  phase_t ph = PH_PRST;
  int     rem = 0;
  int     m_retry = 0;
  logic   m_sync [SYNC];
  bit     m_valid = 1'b0;
  bit     m_lost = 1'b0;

  task automatic model_step();
    logic ls;
    m_lost = 1'b0;
    if (!rst_n) begin
      for (int i = 0; i < SYNC; i++) m_sync[i] = 1'b0;
      ph      = PH_PRST;
      rem     = PRST_LEN;
      m_retry = 0;
      m_valid = 1'b1;
      return;
    end
    ls = m_sync[SYNC-1];
    for (int i = SYNC - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
    m_sync[0] = lock;
    case (ph)
      PH_PRST: begin
        rem--;
        if (rem == 0) begin ph = PH_WAIT; rem = TOUT; end
      end
      PH_WAIT: begin
        if (ls) begin
          ph = PH_QUAL; rem = HOLD;
        end else begin
          rem--;
          if (rem == 0) begin
            if (m_retry == MAXR) ph = PH_FAULT;
            else begin m_retry++; ph = PH_PRST; rem = PRST_LEN; end
          end
        end
      end
      PH_QUAL: begin
        if (!ls) begin
          ph = PH_WAIT; rem = TOUT;
        end else begin
          rem--;
          if (rem == 0) ph = PH_RUN;
        end
      end
      PH_RUN: begin
        if (!ls) begin
          m_lost = 1'b1; m_retry = 0; ph = PH_PRST; rem = PRST_LEN;
        end
      end
      default: ;
    endcase
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      check("model.pll_resetb", pll_resetb_o, (ph == PH_WAIT || ph == PH_QUAL || ph == PH_RUN));
      check("model.sys_rst_n", sys_rst_n_o, (ph == PH_RUN));
      check("model.ready", ready_o, (ph == PH_RUN));
      check("model.fault", fault_o, (ph == PH_FAULT));
      check("model.lock_lost", lock_lost_o, m_lost);
      check("model.retry_cnt", retry_cnt_o, m_retry);
    end
  end

  // Counts posedges (first one = 1) until sys_rst_n_o is seen high; -1 on timeout.
  task automatic edges_until_rstn(input int max, output int k);
    k = -1;
    for (int i = 1; i <= max; i++) begin
      @(posedge clk); #1;
      if (sys_rst_n_o) begin k = i; return; end
    end
  endtask

  initial begin
    int k;
    bit ok;

    // Normal bring-up
    rst_n = 1'b0; lock = 1'b0;
    repeat (3) @(negedge clk);
    check("s1_reset_pll_resetb", pll_resetb_o, 0);
    check("s1_reset_sys_rst_n", sys_rst_n_o, 0);
    check("s1_reset_fault", fault_o, 0);
    check("s1_reset_retry", retry_cnt_o, 0);
    rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      check("s1_prst_pulse", pll_resetb_o, (i == 4) ? 1 : 0);
    end
    repeat (6) @(negedge clk);
    lock = 1'b1;
    edges_until_rstn(40, k);
    check("s1_release_latency", k, 11);
    check("s1_ready", ready_o, 1);
    check("s1_fault", fault_o, 0);

    // Runtime loss of lock
    @(negedge clk);
    lock = 1'b0;
    k = -1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (lock_lost_o) begin k = i; break; end
    end
    check("s4_lost_latency", k, 3);
    check("s4_lost_sys_rst_n", sys_rst_n_o, 0);
    check("s4_lost_ready", ready_o, 0);
    check("s4_lost_retry", retry_cnt_o, 0);
    @(posedge clk); #1;
    check("s4_lost_one_cycle", lock_lost_o, 0);
    check("s4_prst_low", pll_resetb_o, 0);
    for (int i = 5; i <= 7; i++) begin
      @(posedge clk); #1;
      check("s4_prst_pulse", pll_resetb_o, (i == 7) ? 1 : 0);
    end
    @(negedge clk);
    lock = 1'b1;
    edges_until_rstn(40, k);
    check("s4_relock_latency", k, 11);

    // Reset while in RUN
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("s5a_sys_rst_n", sys_rst_n_o, 0);
    check("s5a_ready", ready_o, 0);
    check("s5a_pll_resetb", pll_resetb_o, 0);
    check("s5a_retry", retry_cnt_o, 0);
    @(negedge clk);
    lock = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Lock glitch during HOLD
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pll_resetb_o) begin ok = 1'b1; break; end
    end
    check("s2_wait_pll_high", ok, 1);
    lock = 1'b1;
    repeat (6) @(negedge clk);
    lock = 1'b0;
    @(negedge clk);
    lock = 1'b1;
    edges_until_rstn(40, k);
    check("s2_relock_latency", k, 11);

    // Never-locking PLL, then reset out of FAULT
    @(negedge clk);
    rst_n = 1'b0; lock = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    k = -1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk); #1;
      if (fault_o) begin k = i; break; end
    end
    check("s3_fault_edge", k, 108);
    lock = 1'b1;
    repeat (20) @(negedge clk);
    check("s3_fault_sticky", fault_o, 1);
    check("s3_fault_pll_resetb", pll_resetb_o, 0);
    check("s3_fault_sys_rst_n", sys_rst_n_o, 0);
    check("s3_fault_retry", retry_cnt_o, 2);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("s5b_fault_cleared", fault_o, 0);
    check("s5b_retry", retry_cnt_o, 0);
    check("s5b_pll_resetb", pll_resetb_o, 0);
    @(negedge clk);
    rst_n = 1'b1; lock = 1'b0;

    // Lock arriving on the last cycle of the second window
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (retry_cnt_o == 4'd1) begin ok = 1'b1; break; end
    end
    check("s6_wait_retry1", ok, 1);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (pll_resetb_o) begin ok = 1'b1; break; end
    end
    check("s6_wait_pll_high", ok, 1);
    repeat (29) @(negedge clk);
    lock = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("s6_no_prst", pll_resetb_o, 1);
    check("s6_retry_kept", retry_cnt_o, 1);
    edges_until_rstn(20, k);
    check("s6_run_latency", k, 8);
    check("s6_retry_in_run", retry_cnt_o, 1);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, %0d tests run", n_tests);
    $fatal(1);
  end

endmodule

// File: doc/pll_rst_seq.md
Name: pll_rst_seq

Overview:
Reset sequencer that consumes the lock indication of the on-chip PLL clock generator and produces a clean, synchronous system reset once the generated clock is stable. It runs on the PLL reference clock, so it is alive before lock. It drives the PLL RESETB pin and retries a PLL that fails to lock. After repeated failures it enters a sticky fault state. It also detects loss of lock at runtime and re-sequences.

Parameters:
SYNC_STAGES, 2, number of flops synchronising lock_i (min 2)
LOCK_HOLD, 1024, cycles lock must stay continuously high before reset release
LOCK_TIMEOUT, 65536, cycles spent waiting for lock before a PLL reset retry
PLL_RST_LEN, 16, cycles pll_resetb_o is held low per PLL reset
MAX_RETRY, 3, PLL reset retries allowed before FAULT
CNT_W, 17, shared counter width; must hold max(LOCK_HOLD, LOCK_TIMEOUT, PLL_RST_LEN)

Ports:
clk_i  in  1  reference clock (board oscillator, also feeds PLL REFERENCECLK)
rst_n_i  in  1  synchronous, active-low reset
lock_i  in  1  PLL LOCK output, asynchronous to clk_i
pll_resetb_o  out  1  to PLL RESETB; 0 = PLL held in reset
sys_rst_n_o  out  1  synchronous active-low reset for the downstream design
ready_o  out  1  1 while in RUN
lock_lost_o  out  1  one-cycle pulse on loss of lock during RUN
fault_o  out  1  sticky; PLL failed to lock after MAX_RETRY retries
retry_cnt_o  out  4  retries consumed in the current sequence, saturating at 15

Behaviour:
- lock_i passes through a SYNC_STAGES-deep flop chain; lock_s is the last stage. The FSM uses only lock_s.
- All outputs are registered and update on the same edge as the state register; no combinational paths from inputs to outputs.
- On rst_n_i = 0 at an edge: state = PLL_RST, counter = 0, retry = 0, sync chain = 0, pll_resetb_o = 0, sys_rst_n_o = 0, ready_o = 0, lock_lost_o = 0, fault_o = 0. This applies from any state, including mid-RUN and FAULT.
- PLL_RST: pll_resetb_o = 0; counter counts 0..PLL_RST_LEN-1; at PLL_RST_LEN-1 go to WAIT_LOCK with counter = 0.
- WAIT_LOCK: pll_resetb_o = 1.
  - If lock_s = 1, go to HOLD with counter = 0.
  - Otherwise counter++. At counter = LOCK_TIMEOUT-1: if retry = MAX_RETRY, go to FAULT; else retry++ and go to PLL_RST with counter = 0.
  - If lock_s rises on the timeout cycle, lock wins.
- HOLD: pll_resetb_o = 1.
  - lock_s = 0 returns to WAIT_LOCK with counter = 0, giving a fresh timeout window; retry is unchanged.
  - With lock_s = 1, counter counts 0..LOCK_HOLD-1; at LOCK_HOLD-1 go to RUN.
- RUN: sys_rst_n_o = 1, ready_o = 1.
  - lock_s = 0 causes, on that edge: lock_lost_o = 1 for exactly one cycle, sys_rst_n_o = 0, ready_o = 0, retry = 0, go to PLL_RST.
- FAULT: fault_o = 1, pll_resetb_o = 0, sys_rst_n_o = 0, ready_o = 0. Exit only via rst_n_i.
- Release latency: sys_rst_n_o rises on the (SYNC_STAGES + LOCK_HOLD)th edge after the first edge that samples lock_i = 1 in WAIT_LOCK.
- Total WAIT_LOCK windows before FAULT = MAX_RETRY + 1.
- retry_cnt_o mirrors retry, zero-extended.

Test Plan:
(All scenarios use SYNC_STAGES=2, LOCK_HOLD=8, LOCK_TIMEOUT=32, PLL_RST_LEN=4, MAX_RETRY=2.)
- Normal bring-up: release rst_n_i, raise lock_i 10 cycles later and hold it -> pll_resetb_o low for the first 4 cycles; sys_rst_n_o and ready_o rise exactly 10 edges after lock_i is first sampled high; fault_o = 0.
- Lock glitch in HOLD: lock_i drops for 1 cycle at HOLD count 5 -> return to WAIT_LOCK; after re-lock a full 10-edge delay applies again; sys_rst_n_o never pulses high early.
- Never-locking PLL: lock_i = 0 throughout -> three 32-cycle WAIT_LOCK windows, each preceded by a 4-cycle pll_resetb_o low pulse; retry_cnt_o steps 0, 1, 2; then fault_o = 1, pll_resetb_o = 0, sys_rst_n_o = 0, held indefinitely.
- Runtime loss of lock: in RUN, drop lock_i -> after 2 sync edges lock_lost_o high for exactly 1 cycle with sys_rst_n_o = 0 and retry_cnt_o = 0; PLL_RST low pulse of 4 cycles follows; re-lock returns to RUN.
- Reset mid-operation: assert rst_n_i in RUN, and separately in FAULT -> on the next edge all outputs take reset values, including fault_o = 0; the sequence restarts with PLL_RST.
- Lock on timeout cycle: lock_s rises at WAIT_LOCK count 31 -> go to HOLD; retry_cnt_o unchanged; no PLL reset pulse.
